// File: rtl/mesh_router_node.sv
// mesh_router_node: 5-port XY-routed mesh router with per-input FIFOs, round-robin output arbiters
// and registered valid/ready output stages (port 0 local, 1 N, 2 E, 3 S, 4 W).
module mesh_router_node #(
  parameter int DATA_W     = 32,
  parameter int COORD_W    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5*DATA_W-1:0] in_data,
  input  logic [4:0]          in_valid,
  output logic [4:0]          in_ready,
  output logic [5*DATA_W-1:0] out_data,
  output logic [4:0]          out_valid,
  input  logic [4:0]          out_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem [5][FIFO_DEPTH];
  logic [AW-1:0] rdPtr [5];
  logic [AW-1:0] wrPtr [5];
  logic [AW:0] count [5];
  logic [DATA_W-1:0] head [5];
  logic [COORD_W-1:0] destX [5];
  logic [COORD_W-1:0] destY [5];
  logic [2:0] route [5];
  logic [4:0] req [5];
  logic [2:0] ptr [5];
  logic [2:0] gntIdx [5];
  logic [2:0] cand;
  logic [4:0] push, pop, full, nonEmpty, load, gntValid;
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      head[i] = mem[i][rdPtr[i]];
      full[i] = count[i] == (AW+1)'(FIFO_DEPTH);
      nonEmpty[i] = count[i] != '0;
      destX[i] = head[i][DATA_W-1 -: COORD_W];
      destY[i] = head[i][DATA_W-COORD_W-1 -: COORD_W];
      route[i] = destX[i] > COORD_W'(MY_X) ? 3'd2 :
                 destX[i] < COORD_W'(MY_X) ? 3'd4 :
                 destY[i] > COORD_W'(MY_Y) ? 3'd1 :
                 destY[i] < COORD_W'(MY_Y) ? 3'd3 : 3'd0;
    end
  end
  assign in_ready = reset ? 5'b0 : ~full;
  assign push = in_valid & in_ready;
  // Scan candidates from lowest to highest priority so the last hit is the winner.
  always_comb begin
    pop = '0;
    cand = '0;
    for (int o = 0; o < 5; o++) begin
      load[o] = ~out_valid[o] | out_ready[o];
      for (int i = 0; i < 5; i++) req[o][i] = nonEmpty[i] && route[i] == 3'(o);
      gntValid[o] = load[o] & |req[o];
      gntIdx[o] = '0;
      for (int k = 5; k >= 1; k--) begin
        cand = 3'((32'(ptr[o]) + k) % 5);
        if (req[o][cand]) gntIdx[o] = cand;
      end
      if (gntValid[o]) pop[gntIdx[o]] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++)
      if (push[i]) mem[i][wrPtr[i]] <= in_data[i*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (reset) begin
        rdPtr[i] <= '0;
        wrPtr[i] <= '0;
        count[i] <= '0;
      end else begin
        if (push[i]) wrPtr[i] <= wrPtr[i] + 1'b1;
        if (pop[i]) rdPtr[i] <= rdPtr[i] + 1'b1;
        count[i] <= count[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int o = 0; o < 5; o++) begin
      if (reset) begin
        out_valid[o] <= 1'b0;
        out_data[o*DATA_W +: DATA_W] <= '0;
        ptr[o] <= 3'd4;
      end else if (load[o]) begin
        out_valid[o] <= gntValid[o];
        if (gntValid[o]) begin
          out_data[o*DATA_W +: DATA_W] <= head[gntIdx[o]];
          ptr[o] <= gntIdx[o];
        end
      end
    end
  end
endmodule

// File: tb/tb_mesh_router_node.sv
// tb_mesh_router_node: random + directed stimulus checked every cycle against a queue-based router model.
module tb_mesh_router_node;
  logic clk = 0;
  logic reset = 1;
  logic [159:0] inData = '0;
  logic [159:0] outData;
  logic [4:0] inValid = '0;
  logic [4:0] inReady, outValid;
  logic [4:0] outReady = '1;
  int passCnt = 0;
  int totalCnt = 0;
  int acc;
  logic [31:0] q [5][$];
  logic [31:0] mOd [5];
  logic [4:0] mOv;
  logic [4:0] expReady;
  int mPtr [5];
  bit mInit = 0;
  logic [31:0] t2f [4] = '{32'h3000_0001, 32'h1000_0002, 32'h1200_0003, 32'h0500_0004};
  int t2p [4] = '{2, 3, 1, 4};
  int t5p [4] = '{0, 1, 3, 4};

  always #5 clk = ~clk;

  mesh_router_node #(.DATA_W(32), .COORD_W(4), .FIFO_DEPTH(4), .MY_X(1), .MY_Y(1)) dut (
    .clk(clk), .reset(reset), .in_data(inData), .in_valid(inValid), .in_ready(inReady),
    .out_data(outData), .out_valid(outValid), .out_ready(outReady)
  );

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic int dir(logic [31:0] f);
    int x, y;
    x = int'(f[31:28]);
    y = int'(f[27:24]);
    if (x > 1) return 2;
    if (x < 1) return 4;
    if (y > 1) return 1;
    if (y < 1) return 3;
    return 0;
  endfunction

  // Model of the edge that follows: each free output takes the first requesting head after its pointer.
  task automatic step();
    int sz [5];
    int w, c;
    bit [4:0] popm;
    popm = '0;
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        q[i].delete();
        mOd[i] = '0;
        mPtr[i] = 4;
      end
      mOv = '0;
      return;
    end
    for (int i = 0; i < 5; i++) sz[i] = q[i].size();
    for (int o = 0; o < 5; o++) begin
      if (!mOv[o] || outReady[o]) begin
        w = -1;
        for (int k = 1; k <= 5; k++) begin
          c = (mPtr[o] + k) % 5;
          if (w < 0 && sz[c] > 0 && dir(q[c][0]) == o) w = c;
        end
        if (w >= 0) begin
          mOd[o] = q[w][0];
          mOv[o] = 1'b1;
          mPtr[o] = w;
          popm[w] = 1'b1;
        end else mOv[o] = 1'b0;
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (popm[i]) void'(q[i].pop_front());
      if (inValid[i] && sz[i] < 4) q[i].push_back(inData[i*32 +: 32]);
    end
  endtask

  always @(negedge clk) begin
    if (mInit) begin
      for (int i = 0; i < 5; i++) expReady[i] = !reset && q[i].size() < 4;
      chk("in_ready", 32'(inReady), 32'(expReady));
      chk("out_valid", 32'(outValid), 32'(mOv));
      for (int o = 0; o < 5; o++) chk($sformatf("out_data%0d", o), outData[o*32 +: 32], mOd[o]);
    end
    step();
    mInit = 1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lane(int p, logic [31:0] v);
    inData[p*32 +: 32] = v;
  endtask

  task automatic doReset();
    reset = 1;
    inValid = '0;
    tick();
    reset = 0;
    #1;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_out_valid", 32'(outValid), 0);
    chk("rst_in_ready", 32'(inReady), 0);
    chk("rst_out_data0", outData[31:0], 0);
    reset = 0;
    #1;
    chk("ready_after_rst", 32'(inReady), 32'h1f);
    lane(4, 32'h1100_00AA);
    inValid = 5'b10000;
    tick();
    inValid = '0;
    tick();
    chk("t1_valid", 32'(outValid), 32'b00001);
    chk("t1_data", outData[31:0], 32'h1100_00AA);
    tick();
    chk("t1_gone", 32'(outValid), 0);
    for (int k = 0; k < 4; k++) begin
      lane(0, t2f[k]);
      inValid = 5'b00001;
      tick();
      inValid = '0;
      tick();
      chk($sformatf("t2_valid%0d", k), 32'(outValid), 32'(1) << t2p[k]);
      chk($sformatf("t2_data%0d", k), outData[t2p[k]*32 +: 32], t2f[k]);
      tick();
    end
    doReset();
    lane(2, 32'h1100_00E2);
    lane(4, 32'h1100_00B4);
    inValid = 5'b10100;
    tick();
    inValid = '0;
    tick();
    chk("t3_first", outData[31:0], 32'h1100_00E2);
    tick();
    chk("t3_second", outData[31:0], 32'h1100_00B4);
    chk("t3_valid", 32'(outValid), 32'b00001);
    doReset();
    for (int k = 0; k < 4; k++) lane(t5p[k], 32'h3100_0000 | 32'(t5p[k]));
    inValid = 5'b11011;
    tick();
    inValid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t5_grant%0d", k), outData[95:64], 32'h3100_0000 | 32'(t5p[k]));
    end
    doReset();
    outReady = 5'b11011;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      lane(0, 32'h3100_0010 + 32'(k));
      inValid = 5'b00001;
      if (inReady[0]) acc++;
      tick();
    end
    inValid = '0;
    chk("t4_accepted", 32'(acc), 5);
    chk("t4_full", 32'(inReady[0]), 0);
    chk("t4_hold_valid", 32'(outValid[2]), 1);
    chk("t4_hold_data", outData[95:64], 32'h3100_0010);
    outReady = '1;
    for (int k = 1; k < 5; k++) begin
      tick();
      chk($sformatf("t4_drain%0d", k), outData[95:64], 32'h3100_0010 + 32'(k));
      chk($sformatf("t4_drain_valid%0d", k), 32'(outValid[2]), 1);
    end
    doReset();
    outReady = '0;
    for (int k = 0; k < 3; k++) begin
      lane(0, 32'h3100_0020 + 32'(k));
      lane(4, 32'h1100_0030 + 32'(k));
      inValid = 5'b10001;
      tick();
    end
    inValid = '0;
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("t6_valid", 32'(outValid), 0);
    chk("t6_ready", 32'(inReady), 32'h1f);
    outReady = '1;
    repeat (4) begin
      tick();
      chk("t6_stale", 32'(outValid), 0);
    end
    for (int n = 0; n < 3000; n++) begin
      inValid = 5'($urandom);
      for (int p = 0; p < 5; p++)
        lane(p, {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)), 24'($urandom)});
      outReady = 5'($urandom) | 5'($urandom);
      reset = $urandom_range(0, 199) == 0;
      tick();
    end
    reset = 0;
    inValid = '0;
    outReady = '1;
    repeat (10) tick();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
